// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Grants the SDRAM PHY to one command engine at a time and muxes the granted
// engine's command/address/bank onto the PHY pins. While init has not
// finished, the init engine owns the PHY.
//
// Handshake (refresh, write and read engines): the engine holds *_req high.
// The arbiter answers with *_en, which stays high from the first grant cycle
// through the cycle in which the engine pulses *_done for one cycle. *_en is
// low on the cycle after done. A grant that runs GRANT_TIMEOUT cycles without
// done is aborted, and arb_err pulses for one cycle. A done pulse from an
// engine that is not granted is ignored.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   init_done                 init sequence complete (level)
//   init_cmds/addr/ba         init engine PHY drive
//   atref_req/done/en         refresh engine handshake
//   ref_cmds/addr/ba          refresh engine PHY drive
//   wr_req/done/en            write engine handshake
//   wr_cmds/addr/ba           write engine PHY drive
//   rd_req/done/en            read engine handshake
//   rd_cmds/addr/ba           read engine PHY drive
//   sdr_cmds/addr/ba          to PHY: {cs_n,ras_n,cas_n,we_n}, addr, bank
//   arb_err                   one-cycle pulse on a timeout abort
//   dbg_state                 one-hot FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int BA_W          = 2,
  parameter int GRANT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [3:0]        init_cmds,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [BA_W-1:0]   init_ba,
  input  logic              atref_req,
  input  logic              atref_done,
  output logic              atref_en,
  input  logic [3:0]        ref_cmds,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic [BA_W-1:0]   ref_ba,
  input  logic              wr_req,
  input  logic              wr_done,
  output logic              wr_en,
  input  logic [3:0]        wr_cmds,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic              rd_req,
  input  logic              rd_done,
  output logic              rd_en,
  input  logic [3:0]        rd_cmds,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_ba,
  output logic [3:0]        sdr_cmds,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [BA_W-1:0]   sdr_ba,
  output logic              arb_err,
  output logic [4:0]        dbg_state
);

  localparam int TMO_W = $clog2(GRANT_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [4:0] {
    ST_INIT = 5'b00001,
    ST_ARB  = 5'b00010,
    ST_REF  = 5'b00100,
    ST_WR   = 5'b01000,
    ST_RD   = 5'b10000
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_wr;      // 1: write was the most recent wr/rd grant
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             abort;
  logic             in_grant;

  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign in_grant = (state == ST_REF) || (state == ST_WR) || (state == ST_RD);

  // Next state. Every grant returns through ST_ARB, which gives a guaranteed
  // NOP cycle between grants. Done wins over a same-cycle timeout.
  always_comb begin
    state_next = state;
    abort      = 1'b0;
    case (state)
      ST_INIT: if (init_done) state_next = ST_ARB;
      ST_ARB: begin
        if (atref_req)             state_next = ST_REF;
        else if (wr_req && rd_req) state_next = last_wr ? ST_RD : ST_WR;
        else if (wr_req)           state_next = ST_WR;
        else if (rd_req)           state_next = ST_RD;
      end
      ST_REF: begin
        if (atref_done)   state_next = ST_ARB;
        else if (tmo_hit) begin
          state_next = ST_ARB;
          abort      = 1'b1;
        end
      end
      ST_WR: begin
        if (wr_done)      state_next = ST_ARB;
        else if (tmo_hit) begin
          state_next = ST_ARB;
          abort      = 1'b1;
        end
      end
      ST_RD: begin
        if (rd_done)      state_next = ST_ARB;
        else if (tmo_hit) begin
          state_next = ST_ARB;
          abort      = 1'b1;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INIT;
      last_wr <= 1'b0;
      tmo_cnt <= '0;
      arb_err <= 1'b0;
    end else begin
      state   <= state_next;
      arb_err <= abort;
      // last_wr only moves when a new wr/rd grant is issued; aborts leave it.
      if (state == ST_ARB && state_next == ST_WR) last_wr <= 1'b1;
      if (state == ST_ARB && state_next == ST_RD) last_wr <= 1'b0;
      // Counts cycles spent in the current grant; zero on the first grant cycle.
      if (in_grant) tmo_cnt <= tmo_cnt + TMO_ONE;
      else          tmo_cnt <= '0;
    end
  end

  assign atref_en  = (state == ST_REF);
  assign wr_en     = (state == ST_WR);
  assign rd_en     = (state == ST_RD);
  assign dbg_state = state;

  // PHY mux straight off the registered state: no added latency.
  always_comb begin
    sdr_cmds = CMD_NOP;
    sdr_addr = '0;
    sdr_ba   = '0;
    case (state)
      ST_INIT: begin
        sdr_cmds = init_cmds;
        sdr_addr = init_addr;
        sdr_ba   = init_ba;
      end
      ST_REF: begin
        sdr_cmds = ref_cmds;
        sdr_addr = ref_addr;
        sdr_ba   = ref_ba;
      end
      ST_WR: begin
        sdr_cmds = wr_cmds;
        sdr_addr = wr_addr;
        sdr_ba   = wr_ba;
      end
      ST_RD: begin
        sdr_cmds = rd_cmds;
        sdr_addr = rd_addr;
        sdr_ba   = rd_ba;
      end
      default: begin
        sdr_cmds = CMD_NOP;
        sdr_addr = '0;
        sdr_ba   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Engines 0=refresh, 1=write, 2=read. Each round, the bench picks request
// counts and per-request behaviour (hold time or no done at all). A
// transaction-level model turns these into the expected grant order and grant
// lengths and queues them. A monitor pops one entry per observed grant.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
  localparam int AW = 11;
  localparam int BW = 2;
  localparam int GT = 32;
  localparam int WAIT_BUDGET = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic [3:0] init_cmds = '0;
  logic [AW-1:0] init_addr = '0;
  logic [BW-1:0] init_ba = '0;
  logic [2:0] req_v = '0;
  logic [2:0] done_v = '0;
  logic [3:0] cmd_v [3];
  logic [AW-1:0] addr_v [3];
  logic [BW-1:0] ba_v [3];
  logic atref_en, wr_en, rd_en, arb_err;
  logic [3:0] sdr_cmds;
  logic [AW-1:0] sdr_addr;
  logic [BW-1:0] sdr_ba;
  logic [4:0] dbg_state;
  logic [2:0] en_v;

  assign en_v = {rd_en, wr_en, atref_en};

  sdram_arbiter #(.ADDR_W(AW), .BA_W(BW), .GRANT_TIMEOUT(GT)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .init_cmds(init_cmds), .init_addr(init_addr), .init_ba(init_ba),
    .atref_req(req_v[0]), .atref_done(done_v[0]), .atref_en(atref_en),
    .ref_cmds(cmd_v[0]), .ref_addr(addr_v[0]), .ref_ba(ba_v[0]),
    .wr_req(req_v[1]), .wr_done(done_v[1]), .wr_en(wr_en),
    .wr_cmds(cmd_v[1]), .wr_addr(addr_v[1]), .wr_ba(ba_v[1]),
    .rd_req(req_v[2]), .rd_done(done_v[2]), .rd_en(rd_en),
    .rd_cmds(cmd_v[2]), .rd_addr(addr_v[2]), .rd_ba(ba_v[2]),
    .sdr_cmds(sdr_cmds), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba),
    .arb_err(arb_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random PHY drive from every engine, refreshed each negedge.
  always @(negedge clk) begin
    init_cmds = 4'($urandom);
    init_addr = AW'($urandom);
    init_ba   = BW'($urandom);
    for (int i = 0; i < 3; i++) begin
      cmd_v[i]  = 4'($urandom);
      addr_v[i] = AW'($urandom);
      ba_v[i]   = BW'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int id;
    int len;
    bit tmo;
    bit gap1;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  bit last_wr_m = 1'b0;
  int cnt_p [3];
  int hold_p [3][2];
  bit tmo_p [3][2];

  // Expected grant order from the arbitration rules, queued before stimulus.
  task automatic model_round();
    int c [3];
    int k [3];
    int pick;
    bit first;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      c[i] = cnt_p[i];
      k[i] = 0;
    end
    first = 1'b1;
    while (c[0] + c[1] + c[2] > 0) begin
      if (c[0] > 0)                 pick = 0;
      else if (c[1] > 0 && c[2] > 0) pick = last_wr_m ? 2 : 1;
      else if (c[1] > 0)            pick = 1;
      else                          pick = 2;
      if (pick == 1) last_wr_m = 1'b1;
      if (pick == 2) last_wr_m = 1'b0;
      e.id   = pick;
      e.tmo  = tmo_p[pick][k[pick]];
      e.len  = e.tmo ? GT : hold_p[pick][k[pick]] + 1;
      e.gap1 = !first;
      exp_q.push_back(e);
      first = 1'b0;
      c[pick]--;
      k[pick]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One request by engine id. Raises req, waits for the grant, then either
  // pulses done after 'hold' more cycles or waits for the abort.
  task automatic serve(input int id, input int hold, input bit tmo);
    int t;
    req_v[id] = 1'b1;
    t = 0;
    while (!en_v[id] && t < WAIT_BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (!en_v[id]) begin
      chk($sformatf("grant_wait_%0d", id), 32'(en_v[id]), 32'd1);
      req_v[id] = 1'b0;
      return;
    end
    if (tmo) begin
      t = 0;
      while (en_v[id] && t < GT + 8) begin
        @(negedge clk);
        t++;
      end
      req_v[id] = 1'b0;
    end else begin
      repeat (hold) @(negedge clk);
      done_v[id] = 1'b1;
      req_v[id]  = 1'b0;
      @(negedge clk);
      done_v[id] = 1'b0;
    end
  endtask

  task automatic serve_all(input int id);
    for (int k = 0; k < cnt_p[id]; k++) serve(id, hold_p[id][k], tmo_p[id][k]);
  endtask

  task automatic run_round();
    model_round();
    fork
      serve_all(0);
      serve_all(1);
      serve_all(2);
    join
    repeat (3) @(negedge clk);
    chk("round_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic random_round();
    int r;
    do begin
      cnt_p[0] = $urandom_range(0, 1);
      cnt_p[1] = $urandom_range(0, 2);
      cnt_p[2] = $urandom_range(0, 2);
    end while (cnt_p[0] + cnt_p[1] + cnt_p[2] == 0);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 9);
        hold_p[i][k] = (r == 9) ? GT - 1 : r;
        tmo_p[i][k]  = ($urandom_range(0, 5) == 0);
      end
    end
    run_round();
  endtask

  // ---------------- monitor ----------------
  bit mon_on = 1'b0;
  logic [2:0] prev_en = '0;
  int run_len = 0;
  int gap = 0;
  exp_t cur;

  always @(negedge clk) begin
    #2;
    if (mon_on) begin
      if (en_v != 0 && prev_en != 0 && en_v != prev_en)
        chk("grant_switch_without_gap", 32'(en_v), 32'(prev_en));
      if (en_v != 0 && prev_en == 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(en_v), 32'd0);
          cur.id = -1;
        end else begin
          cur = exp_q.pop_front();
          chk("grant_id", 32'(en_v), 32'(3'b001 << cur.id));
          if (cur.gap1) chk("nop_gap", 32'(gap), 32'd1);
        end
        run_len = 1;
      end else if (en_v != 0) begin
        run_len++;
      end
      if (en_v != 0 && cur.id >= 0) begin
        chk("mux_cmds", 32'(sdr_cmds), 32'(cmd_v[cur.id]));
        chk("mux_addr", 32'(sdr_addr), 32'(addr_v[cur.id]));
        chk("mux_ba",   32'(sdr_ba),   32'(ba_v[cur.id]));
      end
      if (en_v == 0 && prev_en != 0) begin
        if (cur.id >= 0) begin
          chk("grant_len", 32'(run_len), 32'(cur.len));
          chk("arb_err", 32'(arb_err), 32'(cur.tmo));
        end
        gap = 1;
      end else begin
        if (arb_err) chk("arb_err_spurious", 32'(arb_err), 32'd0);
        if (en_v == 0) gap++;
      end
      if (en_v == 0) begin
        if (sdr_cmds !== 4'b0111 || sdr_addr !== '0 || sdr_ba !== '0)
          chk("idle_nop", 32'({sdr_cmds, sdr_ba, sdr_addr}), 32'({4'b0111, 13'd0}));
      end
    end
    prev_en = en_v;
  end

  // ---------------- main sequence ----------------
  int t;
  initial begin
    for (int i = 0; i < 3; i++) begin
      cmd_v[i] = '0;
      addr_v[i] = '0;
      ba_v[i] = '0;
    end
    // Reset state: no grants, PHY follows init engine.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_en", 32'(en_v), 32'd0);
    chk("rst_err", 32'(arb_err), 32'd0);
    chk("rst_cmds", 32'(sdr_cmds), 32'(init_cmds));
    chk("rst_addr", 32'(sdr_addr), 32'(init_addr));
    rst = 1'b0;
    // Requests while init is pending must not be granted.
    req_v[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("init_no_grant", 32'(en_v), 32'd0);
    chk("init_mux", 32'(sdr_cmds), 32'(init_cmds));
    req_v[1] = 1'b0;
    init_done = 1'b1;
    @(negedge clk);
    #3;
    chk("arb_nop_cmds", 32'(sdr_cmds), 32'h7);
    chk("arb_nop_addr", 32'(sdr_addr), 32'd0);
    @(negedge clk);
    mon_on = 1'b1;

    // All three pending: REF, WR, RD, WR.
    cnt_p = '{1, 2, 1};
    hold_p = '{'{2, 0}, '{3, 1}, '{0, 0}};
    tmo_p = '{'{0, 0}, '{0, 0}, '{0, 0}};
    run_round();

    // Read with no done: abort after GT cycles, arb_err pulse.
    cnt_p = '{0, 0, 1};
    tmo_p = '{'{0, 0}, '{0, 0}, '{1, 0}};
    run_round();

    // Done in the last counted cycle: treated as done.
    cnt_p = '{0, 1, 0};
    hold_p = '{'{0, 0}, '{GT - 1, 0}, '{0, 0}};
    tmo_p = '{'{0, 0}, '{0, 0}, '{0, 0}};
    run_round();

    // Refresh rises mid-write: no preemption, REF right after the NOP gap.
    begin
      exp_t e;
      e.id = 1; e.len = 7; e.tmo = 0; e.gap1 = 0;
      exp_q.push_back(e);
      e.id = 0; e.len = 3; e.tmo = 0; e.gap1 = 1;
      exp_q.push_back(e);
      last_wr_m = 1'b1;
      fork
        serve(1, 6, 1'b0);
        begin
          t = 0;
          while (!wr_en && t < 100) begin
            @(negedge clk);
            t++;
          end
          repeat (2) @(negedge clk);
          serve(0, 2, 1'b0);
        end
      join
      repeat (3) @(negedge clk);
      chk("preempt_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end

    for (int r = 0; r < 40; r++) random_round();

    // Async reset in the middle of a refresh grant.
    mon_on = 1'b0;
    req_v[0] = 1'b1;
    t = 0;
    while (!atref_en && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("midref_granted", 32'(atref_en), 32'd1);
    @(negedge clk);
    #3;
    init_done = 1'b0;
    rst = 1'b1;
    #1;
    chk("midref_rst_en", 32'(en_v), 32'd0);
    chk("midref_rst_mux", 32'(sdr_cmds), 32'(init_cmds));
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #3;
      chk("post_rst_no_grant", 32'(en_v), 32'd0);
      chk("post_rst_mux", 32'(sdr_cmds), 32'(init_cmds));
    end
    init_done = 1'b1;
    @(negedge clk);
    #3;
    chk("reinit_arb", 32'(en_v), 32'd0);
    chk("reinit_nop", 32'(sdr_cmds), 32'h7);
    @(negedge clk);
    #3;
    chk("reinit_ref_grant", 32'(en_v), 32'b001);
    done_v[0] = 1'b1;
    req_v[0] = 1'b0;
    @(negedge clk);
    done_v[0] = 1'b0;
    #3;
    chk("reinit_ref_release", 32'(en_v), 32'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
